// File: rtl/axi4_stream_pkg.sv
// Shared definitions for the stream scheduler: FSM state encoding,
// register word offsets and the bank signature.
package axi4_stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_STS = 2'd2
    } state_e;

    localparam int REG_SIGNATURE = 0;
    localparam int REG_ENABLE    = 1;
    localparam int REG_MODE      = 2;
    localparam int REG_STATUS    = 3;
    localparam int REG_CLEAR     = 4;
    localparam int REG_CNT_BASE  = 8;

    localparam logic [15:0] SIGNATURE = 16'hACE1;

endpackage

// File: rtl/axi4_stream_scheduler_rr_arbiter.sv
// Combinational stream picker: round-robin after lastGrant_i (mode 0)
// or lowest requesting index (mode 1).
module rr_arbiter #(
    parameter int C_STREAMS_WIDTH = 2
) (
    input  logic [(1<<C_STREAMS_WIDTH)-1:0] req_i,
    input  logic [C_STREAMS_WIDTH-1:0]      lastGrant_i,
    input  logic                            mode_i,
    output logic [C_STREAMS_WIDTH-1:0]      grant_o,
    output logic                            anyReq_o
);

    localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH;

    logic [C_STREAMS_WIDTH-1:0] idx;

    // Scanning from the lowest priority towards the highest lets the last
    // hit be the winner, so no early exit is needed.
    always_comb begin
        grant_o  = '0;
        idx      = '0;
        anyReq_o = |req_i;
        if (mode_i) begin
            for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
                if (req_i[i]) grant_o = C_STREAMS_WIDTH'(i);
            end
        end else begin
            for (int k = NUM_STREAMS; k >= 1; k--) begin
                idx = lastGrant_i + C_STREAMS_WIDTH'(k);
                if (req_i[idx]) grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_scheduler.sv
// Grants the datamover command/status path to one stream at a time and
// exposes enable, mode, status, watchdog and completion counters on set/get.
module axi4_stream_scheduler
    import axi4_stream_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_STREAMS_WIDTH    = 2,
    parameter int C_PAGEWIDTH        = 16,
    parameter int C_REG_BASE         = 64,
    parameter int C_TIMEOUT_WIDTH    = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [(1<<C_STREAMS_WIDTH)-1:0]    stream_pending,
    input  logic                               cmd_accepted,
    input  logic                               sts_done,
    output logic [C_STREAMS_WIDTH-1:0]         stream_select,
    output logic                               stream_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      set_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      set_addr,
    input  logic                               set_stb,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      get_data,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      get_addr,
    output logic                               busy,
    output logic [63:0]                        debug
);

    localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH;
    localparam int WORD_W      = C_PAGEWIDTH - 2;
    localparam logic [WORD_W-1:0] BASE_WORD = WORD_W'(C_REG_BASE);
    localparam logic [C_TIMEOUT_WIDTH-1:0] WDOG_NEAR = {{(C_TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_e                     state_q, state_d;
    logic [C_STREAMS_WIDTH-1:0] grant_q, grant_d;
    logic [C_STREAMS_WIDTH-1:0] lastGrant_q, lastGrant_d;
    logic [NUM_STREAMS-1:0]     enable_q;
    logic                       mode_q;
    logic                       timeoutFlag_q;
    logic [C_TIMEOUT_WIDTH-1:0] wdog_q;
    logic [15:0]                counters_q [NUM_STREAMS];

    logic [NUM_STREAMS-1:0]     eligible;
    logic [C_STREAMS_WIDTH-1:0] arbGrant;
    logic                       arbAny;
    logic                       cntInc;
    logic [WORD_W-1:0]          setOff, getOff;
    logic                       setInBank, getInBank, regWr;
    logic [C_STREAMS_WIDTH-1:0] cntIdx;
    logic                       unusedBits;

    assign eligible = stream_pending & enable_q;

    rr_arbiter #(
        .C_STREAMS_WIDTH (C_STREAMS_WIDTH)
    ) u_arbiter (
        .req_i       (eligible),
        .lastGrant_i (lastGrant_q),
        .mode_i      (mode_q),
        .grant_o     (arbGrant),
        .anyReq_o    (arbAny)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= '1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // A pending drop during OFFER abandons the grant, but an accept in the
    // same cycle takes precedence because the command is already gone.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        cntInc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arbAny) begin
                    grant_d = arbGrant;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (cmd_accepted) state_d = WAIT_STS;
                else if (!stream_pending[grant_q]) state_d = IDLE;
            end
            WAIT_STS: begin
                if (sts_done) begin
                    cntInc      = 1'b1;
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stream_valid  = (state_q == OFFER);
    assign stream_select = grant_q;
    assign busy          = (state_q != IDLE);

    assign setOff    = set_addr[C_PAGEWIDTH-1:2] - BASE_WORD;
    assign getOff    = get_addr[C_PAGEWIDTH-1:2] - BASE_WORD;
    assign setInBank = set_addr[C_PAGEWIDTH-1:2] >= BASE_WORD;
    assign getInBank = get_addr[C_PAGEWIDTH-1:2] >= BASE_WORD;
    assign regWr     = set_stb && setInBank;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '1;
            mode_q   <= 1'b0;
        end else if (regWr) begin
            if (setOff == WORD_W'(REG_ENABLE)) enable_q <= set_data[NUM_STREAMS-1:0];
            if (setOff == WORD_W'(REG_MODE))   mode_q   <= set_data[0];
        end
    end

    // The flag is raised only on the step into saturation so a software
    // clear sticks even while the FSM is still stuck waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q        <= '0;
            timeoutFlag_q <= 1'b0;
        end else begin
            if (state_q == IDLE || state_d == IDLE) wdog_q <= '0;
            else if (!(&wdog_q)) wdog_q <= wdog_q + 1'b1;

            if (state_q != IDLE && state_d != IDLE && wdog_q == WDOG_NEAR)
                timeoutFlag_q <= 1'b1;
            else if (regWr && setOff == WORD_W'(REG_CLEAR) && set_data[1])
                timeoutFlag_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int m = 0; m < NUM_STREAMS; m++) begin
            if (rst || (regWr && setOff == WORD_W'(REG_CLEAR) && set_data[0]))
                counters_q[m] <= '0;
            else if (cntInc && grant_q == C_STREAMS_WIDTH'(m))
                counters_q[m] <= counters_q[m] + 16'd1;
        end
    end

    assign cntIdx = C_STREAMS_WIDTH'(getOff - WORD_W'(REG_CNT_BASE));

    always_comb begin
        get_data = '0;
        if (getInBank) begin
            case (getOff)
                WORD_W'(REG_SIGNATURE): get_data = C_S_AXI_DATA_WIDTH'({SIGNATURE, 16'(NUM_STREAMS)});
                WORD_W'(REG_ENABLE):    get_data = C_S_AXI_DATA_WIDTH'(enable_q);
                WORD_W'(REG_MODE):      get_data = C_S_AXI_DATA_WIDTH'(mode_q);
                WORD_W'(REG_STATUS):    get_data = C_S_AXI_DATA_WIDTH'({timeoutFlag_q, 21'b0, state_q, 8'(grant_q)});
                default: begin
                    if (getOff >= WORD_W'(REG_CNT_BASE) && getOff < WORD_W'(REG_CNT_BASE + NUM_STREAMS))
                        get_data = C_S_AXI_DATA_WIDTH'({16'b0, counters_q[cntIdx]});
                end
            endcase
        end
    end

    assign debug = {20'(wdog_q), 8'(enable_q), state_q, 8'(grant_q), 26'(stream_pending)};

    assign unusedBits = ^{set_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], set_addr[1:0],
                          get_addr[C_S_AXI_ADDR_WIDTH-1:C_PAGEWIDTH], get_addr[1:0],
                          set_data[C_S_AXI_DATA_WIDTH-1:NUM_STREAMS]};

endmodule

// File: doc/axi4_stream_scheduler.md
Name: axi4_stream_scheduler

Overview:
- Arbitrates the datamover command/status path between NUM_STREAMS per-stream command queues in the AXI4-stream master.
- Drives that master's stream_select/stream_valid inputs.
- Holds each grant until the command has been accepted and its status returned.
- Provides a register bank on the set/get bus for enable mask, arbitration mode, status, watchdog and per-stream completion counters.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, set/get address width
- C_S_AXI_DATA_WIDTH, 32, set/get data width (must be 32)
- C_STREAMS_WIDTH, 2, log2 of stream count; NUM_STREAMS = 1<<C_STREAMS_WIDTH (derived localparam)
- C_PAGEWIDTH, 16, decoded address bits; word address = addr[C_PAGEWIDTH-1:2]
- C_REG_BASE, 64, word offset of this bank (outside the master's 0..8*NUM_STREAMS-1 range)
- C_TIMEOUT_WIDTH, 20, watchdog counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- stream_pending  in  NUM_STREAMS  bit m=1: stream m has both addr and size queued
- cmd_accepted  in  1  pulse on M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY
- sts_done  in  1  pulse on S_AXIS_STS_TVALID && S_AXIS_STS_TREADY
- stream_select  out  C_STREAMS_WIDTH  granted stream index
- stream_valid  out  1  grant offered
- set_data  in  C_S_AXI_DATA_WIDTH  write data
- set_addr  in  C_S_AXI_ADDR_WIDTH  write byte address
- set_stb  in  1  write strobe
- get_data  out  C_S_AXI_DATA_WIDTH  read data, combinational from get_addr
- get_addr  in  C_S_AXI_ADDR_WIDTH  read byte address
- busy  out  1  state != IDLE
- debug  out  64  {timeout_cnt[19:0], enable[7:0] zero-padded, state, grant, stream_pending zero-padded}

Behaviour:
- Reset values:
  - stream_valid=0, stream_select=0, busy=0
  - state=IDLE, last_grant=NUM_STREAMS-1
  - enable=all ones, mode=0, timeout_flag=0
  - counters=0, watchdog=0
- Eligible vector: stream_pending & enable.
- FSM, three states:
  - IDLE: if eligible!=0, register grant and go to OFFER; stream_valid rises on the next cycle (1-cycle latency).
    - mode 0 (round-robin): first eligible index searching upward from last_grant+1, wrapping modulo NUM_STREAMS.
    - mode 1 (fixed priority): lowest eligible index.
  - OFFER: stream_valid=1.
    - On cmd_accepted: go to WAIT_STS, drop stream_valid.
    - If stream_pending[grant] falls without cmd_accepted: return to IDLE, no count, last_grant unchanged.
    - If cmd_accepted and the pending fall occur in the same cycle: cmd_accepted wins.
  - WAIT_STS: stream_valid=0.
    - On sts_done: counter[grant]+=1 (16-bit wrap), last_grant<=grant, go to IDLE.
- stream_select=grant, held constant from the OFFER entry edge until the IDLE exit edge; it never changes while busy.
- Enable/mode writes take effect at the next IDLE decision. Clearing a stream's enable bit mid-grant does not abort the grant.
- Watchdog:
  - Counts cycles in OFFER+WAIT_STS; cleared on entering IDLE.
  - At all-ones it sets sticky timeout_flag and saturates. The FSM keeps waiting (no abort).
- cmd_accepted/sts_done outside their state are ignored.
- Register map, word offset from C_REG_BASE:
  - 0 R: signature {16'hACE1, NUM_STREAMS[15:0]}
  - 1 RW: enable[NUM_STREAMS-1:0]
  - 2 RW: mode bit0
  - 3 R: {timeout_flag, 21'b0, state[1:0], grant zero-extended to 8b}
  - 4 W: bit0 clears all counters; bit1 clears timeout_flag. A clear in the same cycle as an increment wins (counter ends at 0).
  - 8+m R: {16'b0, counter[m]}
  - Unmapped reads return 0; unmapped writes have no effect.
- rst mid-operation returns to reset values in one cycle; stream_valid is 0 the cycle after rst is sampled.

Decomposition:
- Shared package (axi4_stream_pkg): state encodings IDLE=0, OFFER=1, WAIT_STS=2; register word offsets; signature constant 16'hACE1.
- One sub-module: rr_arbiter. It is combinational and parameterised by C_STREAMS_WIDTH; inputs are request vector, last_grant and mode; outputs are grant index and any_req.

Test Plan:
- Reset, then read offset 0 → 32'hACE1_0004; read offset 1 → 32'h0000_000F; stream_valid=0.
- stream_pending=4'b1111, mode 0; pulse cmd_accepted then sts_done per grant → grants 0,1,2,3,0 in order; counters 8..11 read 1,1,1,1 (counter 8 reads 2 after the fifth grant).
- mode=1, pending=4'b1010 for three transactions → every grant is stream 1; write enable=4'b1101 → next grant is stream 3.
- In OFFER on stream 2, drop stream_pending[2] → back to IDLE next cycle; counter 10 unchanged; next grant follows last_grant.
- Grant then withhold sts_done for 2^20 cycles → offset 3 bit31=1 with state=2; write 2 to offset 4 → bit31=0.
- Assert rst during WAIT_STS; also write 1 to offset 4 in the same cycle as sts_done → after rst, stream_valid=0 and busy=0; the counter reads 0 in both cases.
